stage_2: RTL



---
 rtl/stage_2_pkg.sv | 15 +
 rtl/stage_2_if.sv | 27 ++
 rtl/stage_2_watchdog.sv | 49 ++++
 rtl/stage_2.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/stage_2_pkg.sv
// Shared definitions for the final-adder pipeline: data widths, the stage-2
// state encoding and the default CORDIC watchdog limit.
package stage_2_pkg;

    localparam int FLT_DATA_WIDTH    = 32;
    localparam int CORDIC_DATA_WIDTH = 22;
    localparam int TIMEOUT_CYCLES    = 1024;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_ONE = 2'b01,
        WAIT_TWO = 2'b10
    } state_e;

endpackage

// File: rtl/stage_2_if.sv
// Request/response handshake to the shared external CORDIC core; the
// pipeline stage is the master, the core is the slave.
interface stage_2_if #(
    parameter int DW = stage_2_pkg::CORDIC_DATA_WIDTH
);
    import stage_2_pkg::*;

    logic          cordic_start;
    logic [DW-1:0] cordic_in;
    logic          cordic_done;
    logic [DW-1:0] cordic_result;

    modport master (
        output cordic_start,
        output cordic_in,
        input  cordic_done,
        input  cordic_result
    );

    modport slave (
        input  cordic_start,
        input  cordic_in,
        output cordic_done,
        output cordic_result
    );

endinterface

// File: rtl/stage_2_watchdog.sv
// Per-operand timeout counter for the CORDIC wait states. The expiry flag is
// registered, so the owner sees it one enabled cycle after the last count.
module stage_two_watchdog #(
    parameter int TIMEOUT_CYCLES = stage_2_pkg::TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clk_en_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);
    import stage_2_pkg::*;

    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expired_q, expired_d;

    // Count saturates at LAST so the flag cannot be lost to a wrap.
    always_comb begin
        count_d   = count_q;
        expired_d = expired_q;
        if (clear_i) begin
            count_d   = '0;
            expired_d = 1'b0;
        end else if (run_i) begin
            if (count_q == LAST) begin
                expired_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else if (clk_en_i) begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/stage_2.sv
// Final-adder stage 2: runs both operands through one shared CORDIC core in
// turn and hands the results plus forwarded floats to stage 3 with a done pulse.
module stage_2 #(
    parameter int FLT_DATA_WIDTH    = stage_2_pkg::FLT_DATA_WIDTH,
    parameter int CORDIC_DATA_WIDTH = stage_2_pkg::CORDIC_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES    = stage_2_pkg::TIMEOUT_CYCLES
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clk_en_i,
    input  logic                         start_i,
    input  logic [CORDIC_DATA_WIDTH-1:0] x_one_i,
    input  logic [CORDIC_DATA_WIDTH-1:0] x_two_i,
    input  logic [FLT_DATA_WIDTH-1:0]    half_one_i,
    input  logic [FLT_DATA_WIDTH-1:0]    half_two_i,
    input  logic [FLT_DATA_WIDTH-1:0]    square_one_i,
    input  logic [FLT_DATA_WIDTH-1:0]    square_two_i,
    stage_2_if.master                    cordic,
    output logic                         done_o,
    output logic                         error_o,
    output logic                         overrun_o,
    output logic [CORDIC_DATA_WIDTH-1:0] res_one_o,
    output logic [CORDIC_DATA_WIDTH-1:0] res_two_o,
    output logic [FLT_DATA_WIDTH-1:0]    half_out_one_o,
    output logic [FLT_DATA_WIDTH-1:0]    half_out_two_o,
    output logic [FLT_DATA_WIDTH-1:0]    square_out_one_o,
    output logic [FLT_DATA_WIDTH-1:0]    square_out_two_o
);
    import stage_2_pkg::*;

    localparam int CW = CORDIC_DATA_WIDTH;
    localparam int FW = FLT_DATA_WIDTH;

    state_e          state_q, state_d;
    logic            cstart_q, cstart_d;
    logic [CW-1:0]   cin_q, cin_d;
    logic [CW-1:0]   x_two_q, x_two_d;
    logic [FW-1:0]   half_one_q, half_one_d, half_two_q, half_two_d;
    logic [FW-1:0]   square_one_q, square_one_d, square_two_q, square_two_d;
    logic [CW-1:0]   res_one_q, res_one_d, res_two_q, res_two_d;
    logic [FW-1:0]   hout_one_q, hout_one_d, hout_two_q, hout_two_d;
    logic [FW-1:0]   sout_one_q, sout_one_d, sout_two_q, sout_two_d;
    logic            done_q, done_d, error_q, error_d, overrun_q, overrun_d;
    logic            wd_clear, wd_run, wd_expired;
    logic            complete, abort;

    stage_two_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clk_en_i (clk_en_i),
        .clear_i  (wd_clear),
        .run_i    (wd_run),
        .expired_o(wd_expired)
    );

    // A cordic_done in the expiry cycle takes priority over the timeout.
    always_comb begin
        state_d      = state_q;
        cstart_d     = 1'b0;
        cin_d        = cin_q;
        x_two_d      = x_two_q;
        half_one_d   = half_one_q;
        half_two_d   = half_two_q;
        square_one_d = square_one_q;
        square_two_d = square_two_q;
        res_one_d    = res_one_q;
        res_two_d    = res_two_q;
        hout_one_d   = hout_one_q;
        hout_two_d   = hout_two_q;
        sout_one_d   = sout_one_q;
        sout_two_d   = sout_two_q;
        done_d       = 1'b0;
        error_d      = error_q;
        overrun_d    = overrun_q;
        wd_clear     = 1'b0;
        wd_run       = 1'b0;
        complete     = 1'b0;
        abort        = 1'b0;

        case (state_q)
            IDLE: begin
                wd_clear = 1'b1;
                if (start_i) begin
                    x_two_d      = x_two_i;
                    half_one_d   = half_one_i;
                    half_two_d   = half_two_i;
                    square_one_d = square_one_i;
                    square_two_d = square_two_i;
                    cin_d        = x_one_i;
                    cstart_d     = 1'b1;
                    state_d      = WAIT_ONE;
                end
            end
            WAIT_ONE: begin
                if (start_i) overrun_d = 1'b1;
                if (cordic.cordic_done) begin
                    res_one_d = cordic.cordic_result;
                    cin_d     = x_two_q;
                    cstart_d  = 1'b1;
                    wd_clear  = 1'b1;
                    state_d   = WAIT_TWO;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end else begin
                    wd_run = 1'b1;
                end
            end
            WAIT_TWO: begin
                if (start_i) overrun_d = 1'b1;
                if (cordic.cordic_done) begin
                    res_two_d = cordic.cordic_result;
                    complete  = 1'b1;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end else begin
                    wd_run = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Floats are forwarded on both normal completion and timeout abort.
        if (complete || abort) begin
            hout_one_d = half_one_q;
            hout_two_d = half_two_q;
            sout_one_d = square_one_q;
            sout_two_d = square_two_q;
            done_d     = 1'b1;
            error_d    = abort;
            state_d    = IDLE;
            if (abort) begin
                res_one_d = '0;
                res_two_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cstart_q     <= 1'b0;
            cin_q        <= '0;
            x_two_q      <= '0;
            half_one_q   <= '0;
            half_two_q   <= '0;
            square_one_q <= '0;
            square_two_q <= '0;
            res_one_q    <= '0;
            res_two_q    <= '0;
            hout_one_q   <= '0;
            hout_two_q   <= '0;
            sout_one_q   <= '0;
            sout_two_q   <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (clk_en_i) begin
            state_q      <= state_d;
            cstart_q     <= cstart_d;
            cin_q        <= cin_d;
            x_two_q      <= x_two_d;
            half_one_q   <= half_one_d;
            half_two_q   <= half_two_d;
            square_one_q <= square_one_d;
            square_two_q <= square_two_d;
            res_one_q    <= res_one_d;
            res_two_q    <= res_two_d;
            hout_one_q   <= hout_one_d;
            hout_two_q   <= hout_two_d;
            sout_one_q   <= sout_one_d;
            sout_two_q   <= sout_two_d;
            done_q       <= done_d;
            error_q      <= error_d;
            overrun_q    <= overrun_d;
        end
    end

    assign cordic.cordic_start = cstart_q;
    assign cordic.cordic_in    = cin_q;
    assign done_o              = done_q;
    assign error_o             = error_q;
    assign overrun_o           = overrun_q;
    assign res_one_o           = res_one_q;
    assign res_two_o           = res_two_q;
    assign half_out_one_o      = hout_one_q;
    assign half_out_two_o      = hout_two_q;
    assign square_out_one_o    = sout_one_q;
    assign square_out_two_o    = sout_two_q;

endmodule
